// File: rtl/food_place_ctrl.sv
// ============================================================================
// Module      : food_place_ctrl
// Description : Food placement sequencer: draws grid-aligned random candidates,
//               bounds-checks them and queries body occupancy with retries.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module food_place_ctrl #(
    parameter int unsigned X_MIN      = 150,
    parameter int unsigned X_MAX      = 778,
    parameter int unsigned Y_MIN      = 41,
    parameter int unsigned Y_MAX      = 509,
    parameter int unsigned GRID_SHIFT = 3,
    parameter int unsigned MAX_TRIES  = 15,
    parameter int unsigned X_INIT     = 464,
    parameter int unsigned Y_INIT     = 272
) (
    input  logic       clk1,
    input  logic       rst_n,
    input  logic       place_req,
    input  logic [9:0] rand_x,
    input  logic [9:0] rand_y,
    output logic       occ_req,
    output logic [9:0] occ_x,
    output logic [9:0] occ_y,
    input  logic       occ_ack,
    input  logic       occ_hit,
    output logic [9:0] xFood,
    output logic [9:0] yFood,
    output logic       food_valid,
    output logic       place_done,
    output logic       place_fail,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SAMPLE = 3'd1,
        S_CHECK  = 3'd2,
        S_QUERY  = 3'd3,
        S_COMMIT = 3'd4,
        S_FAIL   = 3'd5
    } state_t;

    localparam logic [9:0]  c_align_mask = ~10'((1 << GRID_SHIFT) - 1);
    localparam logic [10:0] c_cell_m1    = 11'((1 << GRID_SHIFT) - 1);
    localparam logic [7:0]  c_max_tries  = 8'(MAX_TRIES);

    state_t     r_state;
    state_t     w_state_next;
    logic [9:0] r_cand_x;
    logic [9:0] r_cand_y;
    logic [7:0] r_try;
    logic [7:0] w_try_inc;
    logic       w_last_try;
    logic       w_in_bounds;

    // 11-bit sums so a candidate near 1023 cannot wrap back into range
    assign w_in_bounds = ({1'b0, r_cand_x} >= 11'(X_MIN)) &&
                         (({1'b0, r_cand_x} + c_cell_m1) <= 11'(X_MAX)) &&
                         ({1'b0, r_cand_y} >= 11'(Y_MIN)) &&
                         (({1'b0, r_cand_y} + c_cell_m1) <= 11'(Y_MAX));

    assign w_try_inc  = r_try + 8'd1;
    assign w_last_try = (w_try_inc == c_max_tries);
    assign busy       = (r_state != S_IDLE);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:   if (place_req) w_state_next = S_SAMPLE;
            S_SAMPLE: w_state_next = S_CHECK;
            S_CHECK: begin
                if (w_in_bounds)     w_state_next = S_QUERY;
                else if (w_last_try) w_state_next = S_FAIL;
                else                 w_state_next = S_SAMPLE;
            end
            S_QUERY: begin
                if (occ_ack) begin
                    if (!occ_hit)        w_state_next = S_COMMIT;
                    else if (w_last_try) w_state_next = S_FAIL;
                    else                 w_state_next = S_SAMPLE;
                end
            end
            S_COMMIT: w_state_next = S_IDLE;
            S_FAIL:   w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_next;
    end

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            r_cand_x   <= '0;
            r_cand_y   <= '0;
            r_try      <= '0;
            occ_req    <= 1'b0;
            occ_x      <= '0;
            occ_y      <= '0;
            xFood      <= 10'(X_INIT);
            yFood      <= 10'(Y_INIT);
            food_valid <= 1'b1;
            place_done <= 1'b0;
            place_fail <= 1'b0;
        end else begin
            place_done <= 1'b0;
            place_fail <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (place_req) begin
                        food_valid <= 1'b0;
                        r_try      <= '0;
                    end
                end
                S_SAMPLE: begin
                    r_cand_x <= rand_x & c_align_mask;
                    r_cand_y <= rand_y & c_align_mask;
                end
                S_CHECK: begin
                    if (w_in_bounds) begin
                        occ_x   <= r_cand_x;
                        occ_y   <= r_cand_y;
                        occ_req <= 1'b1;
                    end else begin
                        r_try <= w_try_inc;
                    end
                end
                S_QUERY: begin
                    if (occ_ack) begin
                        occ_req <= 1'b0;
                        if (occ_hit) r_try <= w_try_inc;
                    end
                end
                S_COMMIT: begin
                    xFood      <= r_cand_x;
                    yFood      <= r_cand_y;
                    food_valid <= 1'b1;
                    place_done <= 1'b1;
                end
                S_FAIL: begin
                    food_valid <= 1'b1;
                    place_fail <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_food_place_ctrl.sv
// ============================================================================
// Module      : tb_food_place_ctrl
// Description : Scoreboard bench for food_place_ctrl with an occupancy responder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_food_place_ctrl;

    logic       clk1;
    logic       rst_n;
    logic       place_req;
    logic [9:0] rand_x;
    logic [9:0] rand_y;
    logic       occ_req;
    logic [9:0] occ_x;
    logic [9:0] occ_y;
    logic       occ_ack;
    logic       occ_hit;
    logic [9:0] xFood;
    logic [9:0] yFood;
    logic       food_valid;
    logic       place_done;
    logic       place_fail;
    logic       busy;

    food_place_ctrl dut (
        .clk1(clk1), .rst_n(rst_n), .place_req(place_req),
        .rand_x(rand_x), .rand_y(rand_y),
        .occ_req(occ_req), .occ_x(occ_x), .occ_y(occ_y),
        .occ_ack(occ_ack), .occ_hit(occ_hit),
        .xFood(xFood), .yFood(yFood), .food_valid(food_valid),
        .place_done(place_done), .place_fail(place_fail), .busy(busy)
    );

    initial clk1 = 1'b0;
    always #5 clk1 = ~clk1;

    typedef struct {
        bit done;
        int fx, fy, hs, cx, cy;
    } exp_t;

    exp_t    sb[$];
    exp_t    tmp;
    int      n_cmp = 0, n_err = 0;
    int      done_cnt = 0, hs_cnt = 0, qcount = 0;
    int      g_dmin = 0, g_dmax = 0;
    bit      hold_ack = 0;
    bit [14:0] hit_plan = '0;
    int      model_x = 464, model_y = 272;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Occupancy unit: answers each query after a random delay, hit per plan
    initial begin
        int dly;
        dly = -1;
        occ_ack = 1'b0;
        occ_hit = 1'b0;
        forever begin
            @(negedge clk1);
            if (occ_ack || !rst_n) begin
                occ_ack = 1'b0;
                occ_hit = 1'b0;
                if (!rst_n) dly = -1;
            end else if (occ_req && !hold_ack) begin
                if (dly < 0) dly = $urandom_range(g_dmax, g_dmin);
                if (dly == 0) begin
                    occ_ack = 1'b1;
                    occ_hit = (qcount < 15) ? hit_plan[qcount] : 1'b1;
                    qcount++;
                    dly = -1;
                end else begin
                    dly--;
                end
            end else if (!occ_req) begin
                dly = -1;
            end
        end
    end

    // Monitor: protocol checks and scoreboard pops on completion pulses
    initial begin
        bit         prev_req;
        logic [9:0] prev_x, prev_y;
        exp_t       e;
        prev_req = 0;
        prev_x = '0;
        prev_y = '0;
        forever begin
            @(posedge clk1);
            #1;
            if (!rst_n) begin
                prev_req = 0;
                continue;
            end
            if (occ_ack) begin
                hs_cnt++;
                chk("occ_req_drop_after_ack", int'(occ_req), 0);
            end else if (occ_req && prev_req) begin
                chk("occ_x_stable", int'(occ_x), int'(prev_x));
                chk("occ_y_stable", int'(occ_y), int'(prev_y));
            end
            if (occ_req && !prev_req && sb.size() != 0) begin
                chk("occ_x_cand", int'(occ_x), sb[0].cx);
                chk("occ_y_cand", int'(occ_y), sb[0].cy);
            end
            if (place_done || place_fail) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_completion: done=%0d fail=%0d with empty scoreboard",
                             place_done, place_fail);
                end else begin
                    e = sb.pop_front();
                    chk("place_done", int'(place_done), int'(e.done));
                    chk("place_fail", int'(place_fail), int'(!e.done));
                    chk("xFood", int'(xFood), e.fx);
                    chk("yFood", int'(yFood), e.fy);
                    chk("food_valid", int'(food_valid), 1);
                    chk("handshakes", hs_cnt, e.hs);
                end
                hs_cnt = 0;
                done_cnt++;
            end
            prev_req = occ_req;
            prev_x   = occ_x;
            prev_y   = occ_y;
        end
    end

    // Reference model: outcome derived from the placement rules directly
    task automatic do_txn(input int rx0, input int ry0, input int rx, input int ry,
                          input int pre_oob, input bit [14:0] plan,
                          input int dmin, input int dmax, input bit poke,
                          output int lat);
        exp_t e;
        int   start;
        bit   inb;
        e.cx   = rx - (rx % 8);
        e.cy   = ry - (ry % 8);
        e.hs   = 0;
        e.done = 0;
        inb = (e.cx >= 150) && (e.cx + 7 <= 778) && (e.cy >= 41) && (e.cy + 7 <= 509);
        if (inb) begin
            for (int i = 0; i < 15 - pre_oob; i++) begin
                e.hs = i + 1;
                if (!plan[i]) begin
                    e.done = 1;
                    break;
                end
            end
        end
        if (e.done) begin
            model_x = e.cx;
            model_y = e.cy;
        end
        e.fx = model_x;
        e.fy = model_y;
        sb.push_back(e);

        @(negedge clk1);
        hit_plan = plan;
        qcount   = 0;
        g_dmin   = dmin;
        g_dmax   = dmax;
        rand_x   = 10'((pre_oob != 0) ? rx0 : rx);
        rand_y   = 10'((pre_oob != 0) ? ry0 : ry);
        place_req = 1'b1;
        start = done_cnt;
        lat = 0;
        for (int c = 0; c < 800; c++) begin
            @(negedge clk1);
            lat++;
            if (pre_oob != 0 && c == 3) begin
                rand_x = 10'(rx);
                rand_y = 10'(ry);
            end
            if (done_cnt != start) break;
            place_req = poke && busy && ($urandom_range(3, 0) == 0);
        end
        place_req = 1'b0;
        if (done_cnt == start) begin
            n_cmp++;
            n_err++;
            $display("FAIL txn_timeout: no completion for rand=(%0d,%0d)", rx, ry);
            void'(sb.pop_front());
        end
    endtask

    initial begin
        int lat;
        int rx, ry, d;
        bit [14:0] plan;
        int bx[5] = '{768, 776, 144, 152, 300};
        int by[5] = '{496, 100, 100, 48, 40};

        rst_n = 1'b0;
        place_req = 1'b0;
        rand_x = '0;
        rand_y = '0;
        repeat (2) @(negedge clk1);
        rst_n = 1'b1;
        repeat (10) @(negedge clk1);
        chk("reset_xFood", int'(xFood), 464);
        chk("reset_yFood", int'(yFood), 272);
        chk("reset_food_valid", int'(food_valid), 1);
        chk("reset_busy", int'(busy), 0);
        chk("reset_occ_req", int'(occ_req), 0);

        do_txn(0, 0, 300, 200, 0, 15'd0, 0, 0, 0, lat);
        chk("min_latency", lat, 5);

        do_txn(10, 10, 400, 300, 2, 15'd0, 0, 0, 0, lat);
        do_txn(0, 0, 400, 300, 0, 15'h7fff, 0, 3, 1, lat);
        do_txn(0, 0, 520, 360, 0, 15'b000_0000_0000_0011, 7, 7, 1, lat);

        for (int i = 0; i < 5; i++) do_txn(0, 0, bx[i], by[i], 0, 15'd0, 0, 2, 0, lat);

        for (int t = 0; t < 24; t++) begin
            if ($urandom_range(1, 0) == 1) begin
                rx = $urandom_range(790, 140);
                ry = $urandom_range(520, 30);
            end else begin
                rx = $urandom_range(1023, 0);
                ry = $urandom_range(1023, 0);
            end
            plan = ($urandom_range(4, 0) == 0) ? 15'h7fff : (15'($urandom) | 15'($urandom));
            d = $urandom_range(7, 0);
            do_txn(0, 0, rx, ry, 0, plan, 0, d, 1, lat);
        end

        // Abandon a query with reset while the responder withholds its ack
        tmp.cx = 400; tmp.cy = 296; tmp.hs = 0; tmp.done = 0; tmp.fx = 0; tmp.fy = 0;
        sb.push_back(tmp);
        hold_ack = 1'b1;
        @(negedge clk1);
        rand_x = 10'd400;
        rand_y = 10'd300;
        place_req = 1'b1;
        @(negedge clk1);
        place_req = 1'b0;
        for (int c = 0; c < 20 && !occ_req; c++) @(negedge clk1);
        chk("query_reached", int'(occ_req), 1);
        repeat (2) @(negedge clk1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_occ_req", int'(occ_req), 0);
        chk("async_rst_xFood", int'(xFood), 464);
        chk("async_rst_yFood", int'(yFood), 272);
        chk("async_rst_food_valid", int'(food_valid), 1);
        chk("async_rst_busy", int'(busy), 0);
        chk("async_rst_occ_x", int'(occ_x), 0);
        sb.delete();
        hs_cnt = 0;
        model_x = 464;
        model_y = 272;
        @(negedge clk1);
        rst_n = 1'b1;
        hold_ack = 1'b0;
        do_txn(0, 0, 600, 400, 0, 15'b101, 0, 2, 1, lat);

        repeat (3) @(negedge clk1);
        chk("scoreboard_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
